// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, register-file, writeback and ID/EX signal bundle for decode_stage
interface decode_stage_if #(
   parameter int COUNT_W = 16
);
   logic [31:0]        if_instruction;
   logic [29:0]        if_pc_seq;
   logic               if_valid;
   logic               flush;
   logic               stall_out;
   logic [4:0]         rf_addr_a;
   logic [4:0]         rf_addr_b;
   logic [31:0]        rf_data_a;
   logic [31:0]        rf_data_b;
   logic               wb_write;
   logic [4:0]         wb_addr;
   logic [31:0]        wb_data;
   logic               ex_valid;
   logic [31:0]        ex_reg_a;
   logic [31:0]        ex_reg_b;
   logic [31:0]        ex_imm;
   logic [25:0]        ex_addr26;
   logic [29:0]        ex_pc_seq;
   logic [2:0]         ex_alu_op;
   logic               ex_alu_src;
   logic [4:0]         ex_dest;
   logic               ex_reg_write;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_is_branch;
   logic               ex_is_jump;
   logic               ex_illegal;
   logic [COUNT_W-1:0] stall_count;

   // decode stage side
   modport slave (
      input  if_instruction, if_pc_seq, if_valid, flush,
      input  rf_data_a, rf_data_b, wb_write, wb_addr, wb_data,
      output stall_out, rf_addr_a, rf_addr_b,
      output ex_valid, ex_reg_a, ex_reg_b, ex_imm, ex_addr26, ex_pc_seq,
      output ex_alu_op, ex_alu_src, ex_dest, ex_reg_write, ex_mem_read,
      output ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal, stall_count
   );

   // fetch / register file / execute side
   modport master (
      output if_instruction, if_pc_seq, if_valid, flush,
      output rf_data_a, rf_data_b, wb_write, wb_addr, wb_data,
      input  stall_out, rf_addr_a, rf_addr_b,
      input  ex_valid, ex_reg_a, ex_reg_b, ex_imm, ex_addr26, ex_pc_seq,
      input  ex_alu_op, ex_alu_src, ex_dest, ex_reg_write, ex_mem_read,
      input  ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal, stall_count
   );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID register, MIPS-subset decode, bypass, load-use stall, ID/EX register
module decode_stage #(
   parameter int COUNT_W = 16
) (
   input logic           clk_i,
   input logic           reset_i,
   decode_stage_if.slave bus
);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // IF/ID pipeline register
   logic               ifid_valid_q;
   logic [31:0]        ifid_instr_q;
   logic [29:0]        ifid_pc_q;

   // ID/EX pipeline register
   logic               ex_valid_q;
   logic [31:0]        ex_reg_a_q, ex_reg_b_q, ex_imm_q;
   logic [25:0]        ex_addr26_q;
   logic [29:0]        ex_pc_seq_q;
   logic [2:0]         ex_alu_op_q;
   logic               ex_alu_src_q;
   logic [4:0]         ex_dest_q;
   logic               ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
   logic               ex_is_branch_q, ex_is_jump_q, ex_illegal_q;
   logic [COUNT_W-1:0] stall_count_q;

   // instruction fields
   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;

   assign opcode   = ifid_instr_q[31:26];
   assign rs       = ifid_instr_q[25:21];
   assign rt       = ifid_instr_q[20:16];
   assign rd       = ifid_instr_q[15:11];
   assign func     = ifid_instr_q[5:0];
   assign imm_sext = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

   // decoded control of the IF/ID instruction
   logic [2:0] dec_alu_op;
   logic       dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
   logic       dec_is_branch, dec_is_jump, dec_illegal;
   logic       dec_reads_rs, dec_reads_rt;
   logic [4:0] dec_dest;

   // opcode/func decode; unsupported encodings read nothing and drive no control
   always_comb begin
      dec_alu_op    = ALU_AND;
      dec_alu_src   = 1'b0;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_is_branch = 1'b0;
      dec_is_jump   = 1'b0;
      dec_illegal   = 1'b0;
      dec_reads_rs  = 1'b0;
      dec_reads_rt  = 1'b0;
      dec_dest      = 5'd0;
      case (opcode)
         OP_RTYPE: begin
            dec_reads_rs  = 1'b1;
            dec_reads_rt  = 1'b1;
            dec_dest      = rd;
            dec_reg_write = 1'b1;
            case (func)
               FN_ADD:  dec_alu_op = ALU_ADD;
               FN_SUB:  dec_alu_op = ALU_SUB;
               FN_AND:  dec_alu_op = ALU_AND;
               FN_OR:   dec_alu_op = ALU_OR;
               FN_SLT:  dec_alu_op = ALU_SLT;
               default: begin
                  dec_illegal   = 1'b1;
                  dec_reads_rs  = 1'b0;
                  dec_reads_rt  = 1'b0;
                  dec_dest      = 5'd0;
                  dec_reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            dec_alu_op    = ALU_ADD;
            dec_alu_src   = 1'b1;
            dec_reads_rs  = 1'b1;
            dec_dest      = rt;
            dec_reg_write = 1'b1;
         end
         OP_LW: begin
            dec_alu_op    = ALU_ADD;
            dec_alu_src   = 1'b1;
            dec_reads_rs  = 1'b1;
            dec_dest      = rt;
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
         end
         OP_SW: begin
            dec_alu_op    = ALU_ADD;
            dec_alu_src   = 1'b1;
            dec_reads_rs  = 1'b1;
            dec_reads_rt  = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_BEQ: begin
            dec_alu_op    = ALU_SUB;
            dec_reads_rs  = 1'b1;
            dec_reads_rt  = 1'b1;
            dec_is_branch = 1'b1;
         end
         OP_J: begin
            dec_is_jump   = 1'b1;
         end
         default: begin
            dec_illegal   = 1'b1;
         end
      endcase
      // $0 is hardwired; never claim a write to it
      if (dec_dest == 5'd0) begin
         dec_reg_write = 1'b0;
      end
   end

   // writeback bypass so a same-cycle register file write is seen by decode
   logic [31:0] opnd_a, opnd_b;
   always_comb begin
      opnd_a = bus.rf_data_a;
      opnd_b = bus.rf_data_b;
      if (bus.wb_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == rs)) begin
         opnd_a = bus.wb_data;
      end
      if (bus.wb_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == rt)) begin
         opnd_b = bus.wb_data;
      end
   end

   // load-use hazard from registered state only, so fetch sees no combinational path
   logic hazard;
   always_comb begin
      hazard = ifid_valid_q && ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0) &&
               (((ex_dest_q == rs) && dec_reads_rs) || ((ex_dest_q == rt) && dec_reads_rt));
   end

   assign bus.stall_out = hazard;
   assign bus.rf_addr_a = rs;
   assign bus.rf_addr_b = rt;

   // IF/ID register: flush kills, stall holds, otherwise capture fetch
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= 32'd0;
         ifid_pc_q    <= 30'd0;
      end else if (bus.flush) begin
         ifid_valid_q <= 1'b0;
      end else if (!hazard) begin
         ifid_valid_q <= bus.if_valid;
         ifid_instr_q <= bus.if_instruction;
         ifid_pc_q    <= bus.if_pc_seq;
      end
   end

   // ID/EX register: bubbles clear valid and control but keep data fields
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ex_valid_q     <= 1'b0;
         ex_reg_a_q     <= 32'd0;
         ex_reg_b_q     <= 32'd0;
         ex_imm_q       <= 32'd0;
         ex_addr26_q    <= 26'd0;
         ex_pc_seq_q    <= 30'd0;
         ex_alu_op_q    <= 3'd0;
         ex_alu_src_q   <= 1'b0;
         ex_dest_q      <= 5'd0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_is_branch_q <= 1'b0;
         ex_is_jump_q   <= 1'b0;
         ex_illegal_q   <= 1'b0;
      end else if (bus.flush || hazard || !ifid_valid_q) begin
         ex_valid_q     <= 1'b0;
         ex_alu_op_q    <= 3'd0;
         ex_alu_src_q   <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_is_branch_q <= 1'b0;
         ex_is_jump_q   <= 1'b0;
         ex_illegal_q   <= 1'b0;
      end else begin
         ex_valid_q     <= 1'b1;
         ex_reg_a_q     <= opnd_a;
         ex_reg_b_q     <= opnd_b;
         ex_imm_q       <= imm_sext;
         ex_addr26_q    <= ifid_instr_q[25:0];
         ex_pc_seq_q    <= ifid_pc_q;
         ex_alu_op_q    <= dec_alu_op;
         ex_alu_src_q   <= dec_alu_src;
         ex_dest_q      <= dec_dest;
         ex_reg_write_q <= dec_reg_write;
         ex_mem_read_q  <= dec_mem_read;
         ex_mem_write_q <= dec_mem_write;
         ex_is_branch_q <= dec_is_branch;
         ex_is_jump_q   <= dec_is_jump;
         ex_illegal_q   <= dec_illegal;
      end
   end

   // saturating stall counter; a flushed stall is not counted
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_count_q <= '0;
      end else if (!bus.flush && hazard && (stall_count_q != {COUNT_W{1'b1}})) begin
         stall_count_q <= stall_count_q + COUNT_W'(1);
      end
   end

   assign bus.ex_valid     = ex_valid_q;
   assign bus.ex_reg_a     = ex_reg_a_q;
   assign bus.ex_reg_b     = ex_reg_b_q;
   assign bus.ex_imm       = ex_imm_q;
   assign bus.ex_addr26    = ex_addr26_q;
   assign bus.ex_pc_seq    = ex_pc_seq_q;
   assign bus.ex_alu_op    = ex_alu_op_q;
   assign bus.ex_alu_src   = ex_alu_src_q;
   assign bus.ex_dest      = ex_dest_q;
   assign bus.ex_reg_write = ex_reg_write_q;
   assign bus.ex_mem_read  = ex_mem_read_q;
   assign bus.ex_mem_write = ex_mem_write_q;
   assign bus.ex_is_branch = ex_is_branch_q;
   assign bus.ex_is_jump   = ex_is_jump_q;
   assign bus.ex_illegal   = ex_illegal_q;
   assign bus.stall_count  = stall_count_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [25:0] addr26;
      logic [29:0] pc;
      logic [2:0]  op;
      logic        src;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        jmp;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] rf [32];
   exp_t        sb [$];
   int          checks = 0;
   int          failures = 0;

   decode_stage_if #(.COUNT_W(4)) bus ();

   decode_stage #(.COUNT_W(4)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign bus.rf_data_a = rf[bus.rf_addr_a];
   assign bus.rf_data_b = rf[bus.rf_addr_b];

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [25:0] addr26, input logic [29:0] pc, input logic [2:0] op,
                               input logic src, input logic [4:0] dest, input logic rw, input logic mr,
                               input logic mw, input logic br, input logic jmp, input logic ill);
      exp_t e;
      e = '{a, b, imm, addr26, pc, op, src, dest, rw, mr, mw, br, jmp, ill};
      return e;
   endfunction

   function automatic exp_t lw_exp(input logic [29:0] pc);
      return mk(32'd5, 32'h1004, 32'd8, 26'h0240008, pc, 3'b010, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic exp_t add2_exp(input logic [29:0] pc);
      return mk(32'h1004, 32'd7, 32'h2820, 26'h0822820, pc, 3'b010, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [29:0] pc, input logic v);
      bus.if_instruction = ins;
      bus.if_pc_seq      = pc;
      bus.if_valid       = v;
   endtask

   // present one fetch word and hold it until the stage accepts it
   task automatic issue(input logic [31:0] ins, input logic [29:0] pc, input logic v, input exp_t e);
      logic st;
      int   guard;
      drive(ins, pc, v);
      if (v) sb.push_back(e);
      guard = 0;
      do begin
         st = bus.stall_out;
         tick();
         guard++;
      end while (st && guard < 8);
      chk("fetch_accept", 32'(st), 32'd0);
   endtask

   // monitor: every real instruction leaving decode is matched against the scoreboard
   always @(negedge clk) begin
      exp_t act;
      if (!reset && bus.ex_valid) begin
         act = '{bus.ex_reg_a, bus.ex_reg_b, bus.ex_imm, bus.ex_addr26, bus.ex_pc_seq, bus.ex_alu_op,
                 bus.ex_alu_src, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_is_branch, bus.ex_is_jump, bus.ex_illegal};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL ex_unexpected actual=%h required=none", act);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (act !== e) begin
               failures++;
               $display("FAIL ex_bundle pc=%h actual=%h required=%h", e.pc, act, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      rf[0] = 32'd0;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      drive(32'd0, 30'd0, 1'b0);
      bus.flush    = 1'b0;
      bus.wb_write = 1'b0;
      bus.wb_addr  = 5'd0;
      bus.wb_data  = 32'd0;
      #1;
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_stall_out", 32'(bus.stall_out), 32'd0);
      chk("rst_stall_count", 32'(bus.stall_count), 32'd0);
      chk("rst_reg_a", bus.ex_reg_a, 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // add $3,$1,$2: visible on ex one edge after capture
      issue(32'h00221820, 30'h10, 1'b1,
            mk(32'd5, 32'd7, 32'h1820, 26'h0221820, 30'h10, 3'b010, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("lat_not_yet", 32'(bus.ex_valid), 32'd0);
      issue(32'd0, 30'd0, 1'b0, '0);
      chk("lat_ex_valid", 32'(bus.ex_valid), 32'd1);

      // lw $4,8($1) ; add $5,$4,$2 -> one stall, one bubble
      issue(32'h8C240008, 30'h20, 1'b1, lw_exp(30'h20));
      drive(32'h00822820, 30'h21, 1'b1);
      sb.push_back(add2_exp(30'h21));
      tick();
      chk("lu_stall_on", 32'(bus.stall_out), 32'd1);
      tick();
      chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
      chk("lu_stall_off", 32'(bus.stall_out), 32'd0);
      chk("lu_count", 32'(bus.stall_count), 32'd1);
      drive(32'd0, 30'd0, 1'b0);
      tick();
      chk("lu_add_dest", 32'(bus.ex_dest), 32'd5);

      // addi $2,$1,-1 with writeback of r1 in the decode cycle
      issue(32'h2022FFFF, 30'h30, 1'b1,
            mk(32'hDEADBEEF, 32'd7, 32'hFFFFFFFF, 26'h022FFFF, 30'h30, 3'b010, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd1;
      bus.wb_data  = 32'hDEADBEEF;
      issue(32'd0, 30'd0, 1'b0, '0);
      bus.wb_write = 1'b0;

      // flush while a load-use stall is pending
      issue(32'h8C240008, 30'h40, 1'b1, lw_exp(30'h40));
      drive(32'h00822820, 30'h41, 1'b1);
      tick();
      chk("fl_stall_pending", 32'(bus.stall_out), 32'd1);
      bus.flush = 1'b1;
      drive(32'd0, 30'd0, 1'b0);
      tick();
      bus.flush = 1'b0;
      chk("fl_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("fl_stall_out", 32'(bus.stall_out), 32'd0);
      chk("fl_count_hold", 32'(bus.stall_count), 32'd1);
      tick();
      chk("fl_ifid_dead", 32'(bus.ex_valid), 32'd0);

      // illegal, $0 destination and the rest of the subset back to back
      issue(32'hFC000000, 30'h50, 1'b1,
            mk(32'd0, 32'd0, 32'd0, 26'h0, 30'h50, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      issue(32'h00220020, 30'h51, 1'b1,
            mk(32'd5, 32'd7, 32'h20, 26'h0220020, 30'h51, 3'b010, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      issue(32'h00223022, 30'h52, 1'b1,
            mk(32'd5, 32'd7, 32'h3022, 26'h0223022, 30'h52, 3'b110, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      issue(32'h00223824, 30'h53, 1'b1,
            mk(32'd5, 32'd7, 32'h3824, 26'h0223824, 30'h53, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      issue(32'h00224025, 30'h54, 1'b1,
            mk(32'd5, 32'd7, 32'h4025, 26'h0224025, 30'h54, 3'b001, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      issue(32'h0022482A, 30'h55, 1'b1,
            mk(32'd5, 32'd7, 32'h482A, 26'h022482A, 30'h55, 3'b111, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      issue(32'hAC220004, 30'h56, 1'b1,
            mk(32'd5, 32'd7, 32'd4, 26'h0220004, 30'h56, 3'b010, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      issue(32'h1022FFFE, 30'h57, 1'b1,
            mk(32'd5, 32'd7, 32'hFFFFFFFE, 26'h022FFFE, 30'h57, 3'b110, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      issue(32'h08000010, 30'h58, 1'b1,
            mk(32'd0, 32'd0, 32'h10, 26'h0000010, 30'h58, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      issue(32'd0, 30'd0, 1'b0, '0);

      // repeated load-use pairs drive the 4-bit counter into saturation
      for (int i = 0; i < 14; i++) begin
         issue(32'h8C240008, 30'(12'h100 + 2 * i), 1'b1, lw_exp(30'(12'h100 + 2 * i)));
         issue(32'h00822820, 30'(12'h101 + 2 * i), 1'b1, add2_exp(30'(12'h101 + 2 * i)));
      end
      issue(32'd0, 30'd0, 1'b0, '0);
      chk("sat_reach", 32'(bus.stall_count), 32'd15);
      for (int i = 0; i < 2; i++) begin
         issue(32'h8C240008, 30'(12'h200 + 2 * i), 1'b1, lw_exp(30'(12'h200 + 2 * i)));
         issue(32'h00822820, 30'(12'h201 + 2 * i), 1'b1, add2_exp(30'(12'h201 + 2 * i)));
      end
      issue(32'd0, 30'd0, 1'b0, '0);
      chk("sat_hold", 32'(bus.stall_count), 32'd15);

      // asynchronous reset between edges with a stall pending
      issue(32'h8C240008, 30'h300, 1'b1, lw_exp(30'h300));
      drive(32'h00822820, 30'h301, 1'b1);
      tick();
      chk("ar_stall_pending", 32'(bus.stall_out), 32'd1);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("ar_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("ar_stall_out", 32'(bus.stall_out), 32'd0);
      chk("ar_stall_count", 32'(bus.stall_count), 32'd0);
      chk("ar_reg_a", bus.ex_reg_a, 32'd0);
      chk("ar_imm", bus.ex_imm, 32'd0);
      chk("ar_ctl", 32'({bus.ex_alu_op, bus.ex_alu_src, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read,
                         bus.ex_mem_write, bus.ex_is_branch, bus.ex_is_jump, bus.ex_illegal}), 32'd0);
      drive(32'd0, 30'd0, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
